// File: rtl/scrolling_display.sv
// Scrolling text engine: 16-char ASCII buffer shown through a 4-digit multiplexed 7-seg window.
// Optional SCROLL_DP_HEARTBEAT_EN blinks the digit-0 decimal point on every scroll tick.
module scrolling_display #(
    parameter int SCROLL_CLK_BITS  = 24,
    parameter int DISPLAY_CLK_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       dsn,
    input  logic       clearn,
    output logic [7:0] segments,
    output logic [3:0] digit_select,
    output logic [7:0] leds
);

    logic [7:0]                  buffer [16];
    logic [4:0]                  length;
    logic [4:0]                  pos;
    logic                        dsn_q;
    logic [SCROLL_CLK_BITS-1:0]  scroll_cnt;
    logic [DISPLAY_CLK_BITS+1:0] disp_cnt;
    logic                        hb;

    logic       write;
    logic       tick;
    logic [4:0] last;
    logic [1:0] sel;
    logic [5:0] period;
    logic [5:0] idx;
    logic [7:0] char;
    logic [7:0] seg_val;

    assign write = !dsn && dsn_q;
    assign tick  = &scroll_cnt;
    assign last  = length + 5'd3;
    // sel counts 0..3 while the active digit goes 3..0, so sel is also the window offset
    assign sel   = disp_cnt[DISPLAY_CLK_BITS+1:DISPLAY_CLK_BITS];

    function automatic logic [7:0] font(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
        case (u)
            8'h30: font = 8'hC0;
            8'h31: font = 8'hF9;
            8'h32: font = 8'hA4;
            8'h33: font = 8'hB0;
            8'h34: font = 8'h99;
            8'h35: font = 8'h92;
            8'h36: font = 8'h82;
            8'h37: font = 8'hF8;
            8'h38: font = 8'h80;
            8'h39: font = 8'h90;
            8'h41: font = 8'h88;
            8'h42: font = 8'h83;
            8'h43: font = 8'hC6;
            8'h44: font = 8'hA1;
            8'h45: font = 8'h86;
            8'h46: font = 8'h8E;
            8'h48: font = 8'h89;
            8'h4C: font = 8'hC7;
            8'h4F: font = 8'hC0;
            8'h50: font = 8'h8C;
            8'h55: font = 8'hC1;
            8'h2D: font = 8'hBF;
            8'h5F: font = 8'hF7;
            default: font = 8'hFF;
        endcase
    endfunction

    // Window lookup: message followed by 4 spaces, period length+4; a short message never wraps
    always_comb begin
        period = {1'b0, length} + 6'd4;
        idx    = {1'b0, pos} + {4'b0, sel};
        if (idx >= period) idx = idx - period;
        char    = (idx < {1'b0, length}) ? buffer[idx[3:0]] : 8'h20;
        seg_val = clearn ? font(char) : 8'hFF;
`ifdef SCROLL_DP_HEARTBEAT_EN
        seg_val[7] = !(sel == 2'd3 && hb);
`else
        seg_val[7] = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) buffer[i] <= 8'h20;
            buffer[0] <= 8'h48;
            buffer[1] <= 8'h45;
            buffer[2] <= 8'h4C;
            buffer[3] <= 8'h4C;
            buffer[4] <= 8'h4F;
            length    <= 5'd5;
            leds      <= 8'h00;
        end else if (!clearn) begin
            length <= 5'd0;
        end else if (write) begin
            leds <= ascii;
            if (length == 5'd16) begin
                for (int i = 0; i < 15; i++) buffer[i] <= buffer[i+1];
                buffer[15] <= ascii;
            end else begin
                buffer[length[3:0]] <= ascii;
                length              <= length + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsn_q      <= 1'b1;
            scroll_cnt <= '0;
            disp_cnt   <= '0;
            hb         <= 1'b0;
            pos        <= 5'd0;
        end else begin
            dsn_q      <= dsn;
            scroll_cnt <= scroll_cnt + 1'b1;
            disp_cnt   <= disp_cnt + 1'b1;
            if (tick) hb <= !hb;
            if (!clearn || length <= 5'd4 || pos > last)
                pos <= 5'd0;
            else if (tick)
                pos <= (pos == last) ? 5'd0 : pos + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segments     <= 8'h89;
            digit_select <= 4'b0111;
        end else begin
            segments     <= seg_val;
            digit_select <= ~(4'b1000 >> sel);
        end
    end

endmodule

// File: tb/tb_scrolling_display.sv
// Directed bench for scrolling_display with short scroll/refresh periods (256 / 16 clocks).
module tb_scrolling_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ascii = 8'h00;
    logic       dsn = 1'b1;
    logic       clearn = 1'b1;
    logic [7:0] segments;
    logic [3:0] digit_select;
    logic [7:0] leds;

    int vectors = 0;
    int errors  = 0;
    int cyc;

    scrolling_display #(.SCROLL_CLK_BITS(8), .DISPLAY_CLK_BITS(4)) dut (
        .clk(clk), .rst(rst), .ascii(ascii), .dsn(dsn), .clearn(clearn),
        .segments(segments), .digit_select(digit_select), .leds(leds)
    );

    always #5 clk = ~clk;

    // Clock count since reset release; its value mod 256 is the scroll phase
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        while (digit_select !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < 200 && segments === exp) else begin
            errors++;
            $error("FAIL %s digit%0d: observed %h expected %h (sel %b, waited %0d)",
                   tag, d, segments, exp, digit_select, n);
        end
    endtask

    task automatic check_window(input logic [7:0] e3, e2, e1, e0, input string tag);
        check_digit(3, e3, tag);
        check_digit(2, e2, tag);
        check_digit(1, e1, tag);
        check_digit(0, e0, tag);
    endtask

    task automatic sync(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 256) != ph && n < 600);
    endtask

    task automatic write_char(input logic [7:0] c, input int low);
        ascii = c;
        dsn = 1'b0;
        repeat (low) @(negedge clk);
        dsn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        repeat (2) @(negedge clk);
        clearn = 1'b1;
    endtask

    function automatic logic [7:0] glyph(input logic [7:0] c);
        case (c)
            8'h30: glyph = 8'hC0; 8'h31: glyph = 8'hF9; 8'h32: glyph = 8'hA4;
            8'h33: glyph = 8'hB0; 8'h34: glyph = 8'h99; 8'h35: glyph = 8'h92;
            8'h36: glyph = 8'h82; 8'h37: glyph = 8'hF8;
            default: glyph = 8'hFF;
        endcase
    endfunction

    logic [7:0] seq [12];
    string msg16;

    initial begin
        repeat (3) @(negedge clk);
        chk8("rst_sel", {4'h0, digit_select}, 8'h07);
        chk8("rst_seg", segments, 8'h89);
        chk8("rst_leds", leds, 8'h00);
        rst = 1'b0;

        // HELLO: pos 0 then pos 1 after the first tick
        check_window(8'h89, 8'h86, 8'hC7, 8'hC7, "hell");
        sync(10);
        check_window(8'h86, 8'hC7, 8'hC7, 8'hC0, "ello");
        chk8("leds_reset", leds, 8'h00);

        // Four characters: no scrolling
        do_clear();
        for (int i = 0; i < 4; i++) write_char(8'h30 + 8'(i), 2);
        check_window(8'hC0, 8'hF9, 8'hA4, 8'hB0, "short");
        chk8("leds_short", leds, 8'h33);
        repeat (10) sync(100);
        check_window(8'hC0, 8'hF9, 8'hA4, 8'hB0, "short_held");

        // Eight characters: period 12
        sync(1);
        do_clear();
        for (int i = 0; i < 8; i++) write_char(8'h30 + 8'(i), 2);
        for (int i = 0; i < 12; i++) seq[i] = (i < 8) ? 8'h30 + 8'(i) : 8'h20;
        for (int p = 0; p < 13; p++) begin
            sync(100);
            check_window(glyph(seq[p % 12]), glyph(seq[(p + 1) % 12]),
                         glyph(seq[(p + 2) % 12]), glyph(seq[(p + 3) % 12]), "scroll8");
        end

        // Long strobe appends one character; lowercase maps to uppercase
        do_clear();
        write_char(8'h41, 20);
        write_char(8'h62, 2);
        write_char(8'h2D, 2);
        check_window(8'h88, 8'h83, 8'hBF, 8'hFF, "one_write");
        chk8("leds_dash", leds, 8'h2D);

        // Full buffer: 17 writes drop the oldest, period 20
        msg16 = "0123456789ABCDEF";
        sync(1);
        do_clear();
        for (int i = 0; i < 16; i++) write_char(msg16[i], 2);
        write_char(8'h39, 2);
        sync(100);
        check_window(8'hF9, 8'hA4, 8'hB0, 8'h99, "full_p0");
        repeat (12) sync(100);
        check_window(8'hA1, 8'h86, 8'h8E, 8'h90, "full_p12");
        repeat (7) sync(100);
        check_window(8'hFF, 8'hF9, 8'hA4, 8'hB0, "full_p19");
        chk8("leds_full", leds, 8'h39);

        // Clear wins over a simultaneous falling strobe
        ascii = 8'h55;
        clearn = 1'b0;
        dsn = 1'b0;
        repeat (2) @(negedge clk);
        check_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, "clear_win");
        chk8("leds_clear", leds, 8'h39);
        clearn = 1'b1;
        dsn = 1'b1;
        repeat (2) @(negedge clk);
        check_window(8'hFF, 8'hFF, 8'hFF, 8'hFF, "after_clear");

        // Reset mid-scroll
        sync(1);
        for (int i = 0; i < 6; i++) write_char(8'h41 + 8'(i), 2);
        sync(50);
        rst = 1'b1;
        #1;
        chk8("rst2_sel", {4'h0, digit_select}, 8'h07);
        chk8("rst2_seg", segments, 8'h89);
        chk8("rst2_leds", leds, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        check_window(8'h89, 8'h86, 8'hC7, 8'hC7, "hell_again");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
